// File: rtl/game_timer_pkg.sv
// Shared game-control definitions: state encoding, datapath widths and the
// default 1 Hz divider used by every block that needs a game-second tick.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } game_state_t;

  localparam int DURATION_W           = 7;
  localparam int BCD_W                = 4;
  localparam int DEFAULT_TICK_DIVIDER = 25000000;

  // Split a 0..99 constant into packed {tens, ones} BCD digits.
  function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned value);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    tens = BCD_W'(value / 32'd10);
    ones = BCD_W'(value % 32'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/game_timer_bcd_down_counter_2d.sv
// Two-digit BCD down counter. Load has priority over decrement, and the
// decrement stops at 00 so the displayed value can never wrap.
module bcd_down_counter_2d
  import game_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_ones,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             zero
);

  // Digit registers: reset and load both take the load value.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      tens <= load_tens;
      ones <= load_ones;
    end else if (dec && !zero) begin
      if (ones == 4'd0) begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end else begin
      tens <= tens;
      ones <= ones;
    end
  end

  // Zero flag for the currently held value.
  always_comb begin
    zero = (tens == 4'd0) && (ones == 4'd0);
  end

endmodule

// File: rtl/game_timer.sv
// Game countdown timer: divides clk down to game seconds, counts down from
// START_SECONDS, and keeps binary and BCD copies of the remaining time.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int TICK_DIVIDER  = DEFAULT_TICK_DIVIDER,
  parameter int START_SECONDS = 99,
  parameter int WARN_SECONDS  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause_toggle,
  output logic [DURATION_W-1:0] game_duration,
  output logic [BCD_W-1:0]      digit_tens,
  output logic [BCD_W-1:0]      digit_ones,
  output logic                  tick,
  output logic                  time_up,
  output logic                  running,
  output logic                  low_time
);

  localparam int PRESC_W = (TICK_DIVIDER > 2) ? $clog2(TICK_DIVIDER) : 1;
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICK_DIVIDER - 1);
  localparam logic [DURATION_W-1:0] START_VAL  = DURATION_W'(START_SECONDS);
  localparam logic [DURATION_W-1:0] WARN_VAL   = DURATION_W'(WARN_SECONDS);
  localparam logic [2*BCD_W-1:0]    START_BCD  = to_bcd(START_SECONDS);

  if (TICK_DIVIDER < 2) begin : g_bad_divider
    $error("game_timer: TICK_DIVIDER must be at least 2");
  end
  if (START_SECONDS < 1 || START_SECONDS > 99) begin : g_bad_start
    $error("game_timer: START_SECONDS must be within 1..99");
  end

  game_state_t           state, next_state;
  logic [PRESC_W-1:0]    presc, presc_next;
  logic [DURATION_W-1:0] duration_next;
  logic                  load, dec;
  logic                  tick_next, time_up_next, low_time_next;
  logic                  bcd_zero;

  // State, prescaler and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      presc         <= '0;
      game_duration <= START_VAL;
      tick          <= 1'b0;
      time_up       <= 1'b0;
      running       <= 1'b0;
      low_time      <= 1'b0;
    end else begin
      state         <= next_state;
      presc         <= presc_next;
      game_duration <= duration_next;
      tick          <= tick_next;
      time_up       <= time_up_next;
      running       <= (next_state == RUNNING);
      low_time      <= low_time_next;
    end
  end

  // Next-state logic: start beats pause_toggle, which beats the terminal count.
  always_comb begin
    next_state   = state;
    presc_next   = presc;
    load         = 1'b0;
    dec          = 1'b0;
    tick_next    = 1'b0;
    time_up_next = 1'b0;
    if (start) begin
      next_state = RUNNING;
      presc_next = '0;
      load       = 1'b1;
    end else begin
      case (state)
        RUNNING: begin
          if (pause_toggle) begin
            next_state = PAUSED;
          end else if (presc == PRESC_LAST) begin
            presc_next = '0;
            if (game_duration != 7'd0) begin
              dec       = 1'b1;
              tick_next = 1'b1;
              if (game_duration == 7'd1) begin
                time_up_next = 1'b1;
                next_state   = EXPIRED;
              end else begin
                time_up_next = 1'b0;
              end
            end else begin
              next_state = EXPIRED;
            end
          end else begin
            presc_next = presc + PRESC_W'(1);
          end
        end
        PAUSED: begin
          if (pause_toggle) begin
            next_state = RUNNING;
          end else begin
            next_state = PAUSED;
          end
        end
        IDLE:    next_state = IDLE;
        EXPIRED: next_state = EXPIRED;
        default: next_state = IDLE;
      endcase
    end
  end

  // Upcoming count, so low_time lines up with the game_duration it describes.
  always_comb begin
    if (load) begin
      duration_next = START_VAL;
    end else if (dec) begin
      duration_next = game_duration - 7'd1;
    end else begin
      duration_next = game_duration;
    end
    low_time_next = (next_state != IDLE) && (duration_next <= WARN_VAL);
  end

  bcd_down_counter_2d u_bcd (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .dec       (dec),
    .load_tens (START_BCD[2*BCD_W-1:BCD_W]),
    .load_ones (START_BCD[BCD_W-1:0]),
    .tens      (digit_tens),
    .ones      (digit_ones),
    .zero      (bcd_zero)
  );

endmodule
